// File: rtl/kb_scan_decoder.sv
// PS/2 set-2 scan byte decoder: strips F0/E0 framing, tracks shift, queues {shift, code} in a FWFT FIFO.
// Define KB_CAPSLOCK_EN to enable caps-lock toggling and caps-adjusted shift on letter codes.
module kb_scan_decoder #(
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   input  logic       rd_en,
   output logic [8:0] rd_data,
   output logic       empty,
   output logic       full,
   output logic       overflow,
   output logic       shift_held,
   output logic       caps_lock
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;

   state_t                r_state;
   logic                  r_lshift;
   logic                  r_rshift;
   logic [8:0]            r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_empty;
   logic                  r_full;
   logic                  r_overflow;

   logic                  w_push;
   logic [8:0]            w_push_data;
   logic                  w_pop;
   logic                  w_do_push;
   logic                  w_shift_eff;
   logic [DEPTH_LOG2:0]   w_count_next;

`ifdef KB_CAPSLOCK_EN
   logic r_caps;
   logic w_is_letter;

   always_comb begin
      w_is_letter = 1'b0;
      case (scan_code)
         8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
         8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
         8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A: w_is_letter = 1'b1;
         default: w_is_letter = 1'b0;
      endcase
   end

   assign w_shift_eff = (r_lshift | r_rshift) ^ (r_caps & w_is_letter);
   assign caps_lock   = r_caps;
`else
   assign w_shift_eff = r_lshift | r_rshift;
   assign caps_lock   = 1'b0;
`endif

   // Decide which scan bytes become FIFO words; framing/modifier/control bytes never do.
   always_comb begin
      w_push      = 1'b0;
      w_push_data = '0;
      if (scan_valid) begin
         case (r_state)
            ST_IDLE: begin
               case (scan_code)
                  8'hF0, 8'hE0, 8'h12, 8'h59, 8'h58,
                  8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: w_push = 1'b0;
                  default: begin
                     w_push      = 1'b1;
                     w_push_data = {w_shift_eff, scan_code};
                  end
               endcase
            end
            ST_EXT: begin
               if (scan_code == 8'h5A || scan_code == 8'h4A) begin
                  w_push      = 1'b1;
                  w_push_data = {1'b0, scan_code};
               end
            end
            default: w_push = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_lshift <= 1'b0;
         r_rshift <= 1'b0;
`ifdef KB_CAPSLOCK_EN
         r_caps   <= 1'b0;
`endif
      end else if (scan_valid) begin
         case (r_state)
            ST_IDLE: begin
               case (scan_code)
                  8'hF0: r_state <= ST_BRK;
                  8'hE0: r_state <= ST_EXT;
                  8'h12: r_lshift <= 1'b1;
                  8'h59: r_rshift <= 1'b1;
`ifdef KB_CAPSLOCK_EN
                  8'h58: r_caps <= ~r_caps;
`endif
                  default: r_state <= ST_IDLE;
               endcase
            end
            ST_BRK: begin
               if (scan_code == 8'h12) r_lshift <= 1'b0;
               if (scan_code == 8'h59) r_rshift <= 1'b0;
               r_state <= (scan_code == 8'hF0) ? ST_BRK : ST_IDLE;
            end
            ST_EXT:  r_state <= (scan_code == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_pop     = rd_en & ~r_empty;
   // A push into a full FIFO still lands when the head is popped on the same edge.
   assign w_do_push = w_push & (~r_full | w_pop);

   always_comb begin
      w_count_next = r_count;
      if (w_do_push && !w_pop) w_count_next = r_count + 1'b1;
      if (!w_do_push && w_pop) w_count_next = r_count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_do_push && rst_n) r_mem[r_wr_ptr] <= w_push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_empty    <= 1'b1;
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_next;
         r_empty <= (w_count_next == '0);
         r_full  <= (w_count_next == (DEPTH_LOG2 + 1)'(DEPTH));
         if (w_push && r_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign rd_data    = r_empty ? '0 : r_mem[r_rd_ptr];
   assign empty      = r_empty;
   assign full       = r_full;
   assign overflow   = r_overflow;
   assign shift_held = r_lshift | r_rshift;

endmodule

// File: tb/tb_kb_scan_decoder.sv
// Bench for kb_scan_decoder: queue-based reference model checked every cycle plus directed literal checks.
// Honours KB_CAPSLOCK_EN the same way as the design.
module tb_kb_scan_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] scan_code = '0;
   logic       scan_valid = 1'b0;
   logic       rd_en = 1'b0;
   logic [8:0] rd_data;
   logic       empty, full, overflow, shift_held, caps_lock;

   int n_cmp = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   kb_scan_decoder #(.DEPTH_LOG2(2)) dut (
      .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
      .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
      .overflow(overflow), .shift_held(shift_held), .caps_lock(caps_lock)
   );

   always #5 clk = ~clk;

   // Reference model: prefix flags remember an outstanding F0 / E0 byte.
   logic [8:0] mq[$];
   bit m_lshift, m_rshift, m_caps, m_ovf, m_brk_pend, m_ext_pend;
   byte unsigned letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

   function automatic bit is_letter(input byte unsigned c);
      foreach (letters[i]) if (letters[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      bit push, pop;
      logic [8:0] w;
      push = 1'b0;
      w = '0;
      if (!rst_n) begin
         mq.delete();
         {m_lshift, m_rshift, m_caps, m_ovf, m_brk_pend, m_ext_pend} = '0;
      end else begin
         pop = rd_en && (mq.size() > 0);
         if (scan_valid) begin
            if (m_ext_pend) begin
               if (m_brk_pend) begin
                  m_brk_pend = 1'b0;
                  m_ext_pend = 1'b0;
               end else if (scan_code == 8'hF0) begin
                  m_brk_pend = 1'b1;
               end else begin
                  if (scan_code == 8'h5A || scan_code == 8'h4A) begin
                     push = 1'b1;
                     w = {1'b0, scan_code};
                  end
                  m_ext_pend = 1'b0;
               end
            end else if (m_brk_pend) begin
               if (scan_code == 8'h12) m_lshift = 1'b0;
               if (scan_code == 8'h59) m_rshift = 1'b0;
               if (scan_code != 8'hF0) m_brk_pend = 1'b0;
            end else if (scan_code == 8'hF0) m_brk_pend = 1'b1;
            else if (scan_code == 8'hE0) m_ext_pend = 1'b1;
            else if (scan_code == 8'h12) m_lshift = 1'b1;
            else if (scan_code == 8'h59) m_rshift = 1'b1;
            else if (scan_code == 8'h58) begin
`ifdef KB_CAPSLOCK_EN
               m_caps = !m_caps;
`endif
            end else if (!(scan_code inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
               push = 1'b1;
               w = {(m_lshift | m_rshift) ^ (m_caps & is_letter(scan_code)), scan_code};
            end
         end
         if (pop) void'(mq.pop_front());
         if (push) begin
            if (mq.size() < 4) mq.push_back(w);
            else m_ovf = 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_empty", 9'(empty), 9'(mq.size() == 0));
         chk("m_full", 9'(full), 9'(mq.size() == 4));
         chk("m_rd_data", rd_data, (mq.size() == 0) ? 9'h000 : mq[0]);
         chk("m_overflow", 9'(overflow), 9'(m_ovf));
         chk("m_shift_held", 9'(shift_held), 9'(m_lshift | m_rshift));
         chk("m_caps_lock", 9'(caps_lock), 9'(m_caps));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      scan_code = b;
      scan_valid = 1'b1;
      step();
      scan_valid = 1'b0;
   endtask

   task automatic pop_exp(input string name, input logic [8:0] exp);
      chk(name, rd_data, exp);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      chk_en = 1'b1;
      chk("rst_empty", 9'(empty), 9'h1);
      chk("rst_full", 9'(full), 9'h0);
      chk("rst_rd_data", rd_data, 9'h000);

      // single make code, one-cycle latency, pop
      send(8'h1C);
      chk("t1_empty", 9'(empty), 9'h0);
      pop_exp("t1_pop", 9'h01C);
      chk("t1_empty_after", 9'(empty), 9'h1);
      chk("t1_data_after", rd_data, 9'h000);
      rd_en = 1'b1; step(); rd_en = 1'b0;
      chk("t1_underflow", 9'(empty), 9'h1);

      // shift tracking
      send(8'h12);
      chk("t2_shift_on", 9'(shift_held), 9'h1);
      send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
      chk("t2_shift_off", 9'(shift_held), 9'h0);
      send(8'h1C);
      pop_exp("t2_pop0", 9'h11C);
      pop_exp("t2_pop1", 9'h01C);
      send(8'h59); send(8'h15);
      send(8'hF0); send(8'h59);
      pop_exp("t2_rshift", 9'h115);

      // fill and overflow
      send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
      chk("t3_full", 9'(full), 9'h1);
      chk("t3_ovf_pre", 9'(overflow), 9'h0);
      send(8'h2E);
      chk("t3_ovf", 9'(overflow), 9'h1);
      pop_exp("t3_pop0", 9'h016);
      pop_exp("t3_pop1", 9'h01E);
      pop_exp("t3_pop2", 9'h026);
      pop_exp("t3_pop3", 9'h025);
      chk("t3_empty", 9'(empty), 9'h1);

      // extended framing
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hE0); send(8'h5A);
      send(8'hAA);
      pop_exp("t4_pop", 9'h05A);
      chk("t4_empty", 9'(empty), 9'h1);
      send(8'h1C);
      pop_exp("t4_idle", 9'h01C);

      // simultaneous push/pop on full, then reset mid-break
      do_reset();
      send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
      scan_code = 8'h45; scan_valid = 1'b1; rd_en = 1'b1;
      step();
      scan_valid = 1'b0; rd_en = 1'b0;
      chk("t5_full", 9'(full), 9'h1);
      chk("t5_ovf", 9'(overflow), 9'h0);
      pop_exp("t5_pop0", 9'h01E);
      pop_exp("t5_pop1", 9'h026);
      pop_exp("t5_pop2", 9'h025);
      pop_exp("t5_pop3", 9'h045);
      send(8'hF0);
      do_reset();
      send(8'h12);
      chk("t5_shift", 9'(shift_held), 9'h1);
      chk("t5_empty", 9'(empty), 9'h1);

      // caps lock
      do_reset();
      send(8'h58); send(8'hF0); send(8'h58); send(8'h1C); send(8'h16);
`ifdef KB_CAPSLOCK_EN
      chk("t6_caps", 9'(caps_lock), 9'h1);
      pop_exp("t6_pop0", 9'h11C);
      pop_exp("t6_pop1", 9'h016);
      send(8'h12); send(8'h1C);
      pop_exp("t6_pop2", 9'h01C);
`else
      chk("t6_caps", 9'(caps_lock), 9'h0);
      pop_exp("t6_pop0", 9'h01C);
      pop_exp("t6_pop1", 9'h016);
      send(8'h12); send(8'h1C);
      pop_exp("t6_pop2", 9'h11C);
`endif
      chk("t6_empty", 9'(empty), 9'h1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
